prog_loader: RTL and testbench

- Byte-stream program loader. It is the writer side of the processor's instruction and constant-data memories, which the CPU only ever reads.
- Parses a framed byte stream, for example from a UART receiver, and assembles little-endian 32-bit words.
- Writes each word into INSTR_MEM or DATA_CONST_MEM through a single write port.
- Holds the CPU in reset while a load is in progress or after a failed load.

---
 rtl/prog_loader_pkg.sv | 24 ++
 rtl/prog_loader_if.sv | 25 ++
 rtl/prog_loader_timeout.sv | 31 +++
 rtl/prog_loader.sv | 180 ++++++++++++++++++
 tb/tb_prog_loader.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the byte-stream program loader: frame constants,
// FSM state encoding and the COUNT-byte decode helper.
package prog_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] TGT_INSTR = 8'h00;
    localparam logic [7:0] TGT_CONST = 8'h01;
    localparam int         MAX_WORDS = 128;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TARGET  = 3'd1,
        S_COUNT   = 3'd2,
        S_PAYLOAD = 3'd3,
        S_WRITE   = 3'd4,
        S_CHECK   = 3'd5
    } state_t;

    // A COUNT byte of zero stands for a full 128-word image.
    function automatic logic [7:0] decode_count(input logic [7:0] count);
        return (count == 8'h00) ? 8'(MAX_WORDS) : count;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and memory write port of the program loader.
// Handshake: a byte moves when RX_VALID && RX_READY are both high at a rising
// CLK edge; the source holds RX_DATA stable while RX_VALID is high and ready
// is low, and RX_READY may depend on loader state only, never on RX_VALID.
interface prog_loader_if #(
    parameter int ADDR_W = 7
);
    logic [7:0]        RX_DATA;
    logic              RX_VALID;
    logic              RX_READY;
    logic              MEM_WE;
    logic              MEM_SEL;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [31:0]       MEM_WDATA;

    modport master (
        input  RX_DATA, RX_VALID,
        output RX_READY, MEM_WE, MEM_SEL, MEM_ADDR, MEM_WDATA
    );

    modport slave (
        output RX_DATA, RX_VALID,
        input  RX_READY, MEM_WE, MEM_SEL, MEM_ADDR, MEM_WDATA
    );
endinterface

// File: rtl/prog_loader_timeout.sv
// Inter-byte watchdog: reloads on every accepted byte, counts down while
// enabled and flags expiry once TIMEOUT cycles pass without a byte.
module prog_loader_timeout #(
    parameter int TIMEOUT = 1000000,
    parameter int W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic expire
);

    localparam logic [W-1:0] RELOAD = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    // Down-counter: reload on a byte, otherwise tick toward zero while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= RELOAD;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = enable && !restart && (cnt == '0);

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: SYNC, TARGET, COUNT, COUNT*4 payload bytes
// (little-endian words), CHK = XOR of payload. Writes the words through a
// single memory port and holds the CPU in reset while loading or after a
// failed load.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE     = prog_loader_pkg::SYNC_BYTE,
    parameter int          ADDR_W        = 7,
    parameter int          TIMEOUT       = 1000000,
    parameter bit          HOLD_AT_RESET = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    prog_loader_if.master         io,
    output logic                  CPU_HOLD,
    output logic                  BUSY,
    output logic                  LOAD_DONE,
    output logic                  LOAD_ERR,
    output state_t                DBG_STATE
);

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [7:0]        chk_q, chk_d;
    logic              hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              rx_fire;
    logic              tmo_expire;
    logic [ADDR_W:0]   addr_next;

    assign io.RX_READY = (state_q != S_WRITE);
    assign rx_fire     = io.RX_VALID && io.RX_READY;
    assign addr_next   = {1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1};

    prog_loader_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .restart (rx_fire),
        .enable  (state_q != S_IDLE),
        .expire  (tmo_expire)
    );

    // State and datapath registers; async reset drops everything at once.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            words_q <= '0;
            chk_q   <= '0;
            hold_q  <= HOLD_AT_RESET;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            words_q <= words_d;
            chk_q   <= chk_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Frame parser: next state and next datapath values.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        words_d = words_q;
        chk_d   = chk_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Anything but SYNC is swallowed; an old error stays visible.
                if (rx_fire && io.RX_DATA == SYNC_BYTE) begin
                    state_d = S_TARGET;
                    busy_d  = 1'b1;
                    hold_d  = 1'b1;
                    chk_d   = '0;
                end
            end
            S_TARGET: begin
                if (rx_fire) begin
                    if (io.RX_DATA == TGT_INSTR || io.RX_DATA == TGT_CONST) begin
                        sel_d   = io.RX_DATA[0];
                        state_d = S_COUNT;
                    end else begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_COUNT: begin
                if (rx_fire) begin
                    if (io.RX_DATA <= 8'(MAX_WORDS)) begin
                        words_d = (ADDR_W+1)'(decode_count(io.RX_DATA));
                        addr_d  = '0;
                        idx_d   = '0;
                        state_d = S_PAYLOAD;
                    end else begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_PAYLOAD: begin
                // SYNC-valued bytes here are plain data.
                if (rx_fire) begin
                    wdata_d[{idx_q, 3'b000} +: 8] = io.RX_DATA;
                    chk_d = chk_q ^ io.RX_DATA;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                addr_d  = addr_next[ADDR_W-1:0];
                state_d = (addr_next == words_q) ? S_CHECK : S_PAYLOAD;
            end
            S_CHECK: begin
                if (rx_fire) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                    if (io.RX_DATA == chk_q) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                        err_d  = 1'b0;
                    end else begin
                        // Image is partial: keep the CPU held.
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A stalled frame is abandoned; the CPU stays held.
        if (tmo_expire) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    assign io.MEM_WE    = (state_q == S_WRITE);
    assign io.MEM_SEL   = sel_q;
    assign io.MEM_ADDR  = addr_q;
    assign io.MEM_WDATA = wdata_q;
    assign CPU_HOLD     = hold_q;
    assign BUSY         = busy_q;
    assign LOAD_DONE    = done_q;
    assign LOAD_ERR     = err_q;
    assign DBG_STATE    = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frame vectors from a table plus hand-written
// timeout and mid-frame reset sequences.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int TMO = 50;

    logic   CLK = 1'b0;
    logic   RESET_N = 1'b0;
    logic   cpu_hold, busy, load_done, load_err;
    state_t dbg_state;

    int tests = 0;
    int fails = 0;

    prog_loader_if #(.ADDR_W(7)) bus();

    prog_loader #(
        .SYNC_BYTE     (8'hA5),
        .ADDR_W        (7),
        .TIMEOUT       (TMO),
        .HOLD_AT_RESET (1'b0)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .io        (bus),
        .CPU_HOLD  (cpu_hold),
        .BUSY      (busy),
        .LOAD_DONE (load_done),
        .LOAD_ERR  (load_err),
        .DBG_STATE (dbg_state)
    );

    // Clock and watchdog
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected writes {sel, addr, data} and a memory model
    logic [39:0] exp_q[$];
    logic [31:0] instr_mem[128];
    logic [31:0] const_mem[128];
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          rdy_viol = 0;
    logic [6:0]  last_addr = '0;

    always @(negedge CLK) begin
        if (RESET_N) begin
            if (bus.RX_READY == bus.MEM_WE) rdy_viol++;
            if (load_done) done_cnt++;
            if (bus.MEM_WE) begin
                wr_cnt++;
                last_addr = bus.MEM_ADDR;
                if (bus.MEM_SEL) const_mem[bus.MEM_ADDR] = bus.MEM_WDATA;
                else             instr_mem[bus.MEM_ADDR] = bus.MEM_WDATA;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(wr_cnt), 64'(0));
                end else begin
                    check("write", 64'({bus.MEM_SEL, bus.MEM_ADDR, bus.MEM_WDATA}),
                          64'(exp_q.pop_front()));
                end
            end
        end
    end

    // Driver tasks
    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int   guard;
        acc   = 1'b0;
        guard = 0;
        @(negedge CLK);
        bus.RX_DATA  = b;
        bus.RX_VALID = 1'b1;
        forever begin
            acc = bus.RX_READY;
            @(posedge CLK);
            if (acc || guard >= 20) break;
            guard++;
            @(negedge CLK);
        end
        check("rx_accept", 64'(acc), 64'(1));
    endtask

    task automatic rx_idle();
        @(negedge CLK);
        bus.RX_VALID = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  tgt;
        logic [7:0]  cnt;
        logic [7:0]  chk_xor;
        logic [31:0] w0;
        logic [31:0] w1;
        int          exp_words;
        logic        exp_done;
        logic        exp_err;
        logic        exp_hold;
    } vec_t;

    function automatic logic [31:0] word_of(input vec_t v, input int i);
        if (i == 0) return v.w0;
        if (i == 1) return v.w1;
        return {8'(i), 8'hA5, 8'(255 - i), 8'(i * 3)};
    endfunction

    task automatic run_frame(input vec_t v);
        logic [7:0]  chk;
        logic [31:0] w;
        int          n;
        chk = 8'h00;
        send_byte(8'h5A);
        send_byte(8'hA5);
        #1;
        check("busy_hold_after_sync", 64'({busy, cpu_hold}), 64'(2'b11));
        send_byte(v.tgt);
        if (v.tgt <= 8'h01) begin
            send_byte(v.cnt);
            if (v.cnt <= 8'd128) begin
                n = (v.cnt == 8'h00) ? 128 : int'(v.cnt);
                for (int i = 0; i < n; i++) begin
                    w = word_of(v, i);
                    exp_q.push_back({v.tgt[0], 7'(i), w});
                    for (int k = 0; k < 4; k++) begin
                        chk = chk ^ w[8*k +: 8];
                        send_byte(w[8*k +: 8]);
                    end
                end
                send_byte(chk ^ v.chk_xor);
            end
        end
        rx_idle();
    endtask

    vec_t vecs[6];

    initial begin
        int wr0, dn0, n;
        logic [48:0] rst_vals;

        vecs[0] = '{8'h00, 8'h02, 8'h00, 32'hE59F1204, 32'hE59F2204, 2,   1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h02, 8'h01, 32'hE59F1204, 32'hE59F2204, 2,   1'b0, 1'b1, 1'b1};
        vecs[2] = '{8'h02, 8'h00, 8'h00, 32'h0,        32'h0,        0,   1'b0, 1'b1, 1'b1};
        vecs[3] = '{8'h01, 8'h01, 8'h00, 32'h00000005, 32'h0,        1,   1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 8'h81, 8'h00, 32'h0,        32'h0,        0,   1'b0, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 8'h00, 32'h12345678, 32'h9ABCDEF0, 128, 1'b1, 1'b0, 1'b0};

        bus.RX_DATA  = 8'h00;
        bus.RX_VALID = 1'b0;

        // Reset state
        #1;
        rst_vals = {1'b1, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE};
        check("reset_outputs", 64'({bus.RX_READY, bus.MEM_WE, bus.MEM_SEL, bus.MEM_ADDR,
              bus.MEM_WDATA, cpu_hold, busy, load_done, load_err, dbg_state}), 64'(rst_vals));
        @(negedge CLK);
        RESET_N = 1'b1;

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            wr0 = wr_cnt;
            dn0 = done_cnt;
            run_frame(vecs[i]);
            repeat (3) @(negedge CLK);
            check($sformatf("v%0d_writes", i), 64'(wr_cnt - wr0), 64'(vecs[i].exp_words));
            check($sformatf("v%0d_done", i), 64'(done_cnt - dn0), 64'(vecs[i].exp_done));
            check($sformatf("v%0d_err", i), 64'(load_err), 64'(vecs[i].exp_err));
            check($sformatf("v%0d_hold", i), 64'(cpu_hold), 64'(vecs[i].exp_hold));
            check($sformatf("v%0d_busy", i), 64'(busy), 64'(0));
            check($sformatf("v%0d_state", i), 64'(dbg_state), 64'(S_IDLE));
            check($sformatf("v%0d_queue", i), 64'(exp_q.size()), 64'(0));
            if (i == 0) begin
                check("instr0", 64'(instr_mem[0]), 64'(32'hE59F1204));
                check("instr1", 64'(instr_mem[1]), 64'(32'hE59F2204));
            end
        end
        check("const0", 64'(const_mem[0]), 64'(32'h00000005));
        check("last_addr", 64'(last_addr), 64'(127));
        check("instr127", 64'(instr_mem[127]), 64'(word_of(vecs[5], 127)));

        // Stall two bytes into the payload until the watchdog fires
        check("err_before_timeout", 64'(load_err), 64'(0));
        wr0 = wr_cnt;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        #1 bus.RX_VALID = 1'b0;
        n = 0;
        while (n < 200) begin
            @(posedge CLK);
            #1;
            n++;
            if (load_err) break;
        end
        check("timeout_cycles", 64'(n), 64'(TMO));
        check("timeout_busy", 64'(busy), 64'(0));
        check("timeout_hold", 64'(cpu_hold), 64'(1));
        check("timeout_state", 64'(dbg_state), 64'(S_IDLE));
        check("timeout_writes", 64'(wr_cnt - wr0), 64'(0));

        // Asynchronous reset in the middle of the second payload word
        wr0 = wr_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        exp_q.push_back({1'b1, 7'd0, 32'hCAFEF00D});
        send_byte(8'h0D);
        send_byte(8'hF0);
        send_byte(8'hFE);
        send_byte(8'hCA);
        send_byte(8'h33);
        send_byte(8'h44);
        #1 bus.RX_VALID = 1'b0;
        @(negedge CLK);
        check("pre_reset_sel_addr", 64'({bus.MEM_SEL, bus.MEM_ADDR}), 64'({1'b1, 7'd1}));
        RESET_N = 1'b0;
        #1;
        check("midframe_reset_outputs", 64'({bus.RX_READY, bus.MEM_WE, bus.MEM_SEL, bus.MEM_ADDR,
              bus.MEM_WDATA, cpu_hold, busy, load_done, load_err, dbg_state}), 64'(rst_vals));
        @(negedge CLK);
        RESET_N = 1'b1;
        check("reset_writes", 64'(wr_cnt - wr0), 64'(1));
        check("const0_after_reset", 64'(const_mem[0]), 64'(32'hCAFEF00D));

        // Recovery after reset
        dn0 = done_cnt;
        run_frame(vecs[3]);
        repeat (3) @(negedge CLK);
        check("recover_done", 64'(done_cnt - dn0), 64'(1));
        check("recover_const0", 64'(const_mem[0]), 64'(32'h00000005));
        check("ready_vs_write", 64'(rdy_viol), 64'(0));
        check("final_queue", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
